ysyx_22050854_ifu_fetch: RTL and testbench

- Instruction fetch unit. It sits downstream of the PC unit and is the consumer of its `pc` output.
- It takes the current fetch PC and issues a read on the instruction-memory bus, which is a simplified AR/R valid/ready channel.
- It selects the 32-bit word from the 64-bit beat and presents it in the IF/ID register.
- `if_id_valid` is the IDreg_valid seen by the PC unit. The decode stage's stall/flush controls when that register is consumed or discarded.

---
 rtl/ysyx_22050854_ifu_fetch.sv | 142 ++++++++++++++
 tb/tb_ysyx_22050854_ifu_fetch.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050854_ifu_fetch.sv
// Instruction fetch: issues one AR/R read per PC, picks the 32-bit word and holds it in IF/ID.
// At most one read is in flight; no read is issued while IF/ID is valid.
module ysyx_22050854_ifu_fetch #(
  parameter logic [31:0] RESET_INST = 32'h00000013,
  parameter logic [31:0] ERR_INST   = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  input  logic        stall,
  input  logic        flush,
  output logic        mem_arvalid,
  output logic [31:0] mem_araddr,
  input  logic        mem_arready,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  output logic        mem_rready,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state, state_nxt;
  logic        arvalid_q, arvalid_nxt;
  logic [31:0] araddr_q, araddr_nxt;
  logic        rready_q, rready_nxt;
  logic        valid_q, valid_nxt;
  logic [31:0] pc_q, pc_nxt;
  logic [31:0] inst_q, inst_nxt;
  logic        err_q, err_nxt;
  logic        drop_q, drop_nxt;
  logic [31:0] req_pc_q, req_pc_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      arvalid_q <= 1'b0;
      araddr_q  <= 32'h0;
      rready_q  <= 1'b0;
      valid_q   <= 1'b0;
      pc_q      <= 32'h0;
      inst_q    <= RESET_INST;
      err_q     <= 1'b0;
      drop_q    <= 1'b0;
      req_pc_q  <= 32'h0;
    end else begin
      state     <= state_nxt;
      arvalid_q <= arvalid_nxt;
      araddr_q  <= araddr_nxt;
      rready_q  <= rready_nxt;
      valid_q   <= valid_nxt;
      pc_q      <= pc_nxt;
      inst_q    <= inst_nxt;
      err_q     <= err_nxt;
      drop_q    <= drop_nxt;
      req_pc_q  <= req_pc_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    arvalid_nxt = arvalid_q;
    araddr_nxt  = araddr_q;
    rready_nxt  = rready_q;
    valid_nxt   = valid_q;
    pc_nxt      = pc_q;
    inst_nxt    = inst_q;
    err_nxt     = err_q;
    drop_nxt    = drop_q;
    req_pc_nxt  = req_pc_q;

    // IF/ID consume/flush; flush wins over stall
    if (flush) begin
      valid_nxt = 1'b0;
      err_nxt   = 1'b0;
      inst_nxt  = RESET_INST;
    end else if (valid_q && !stall) begin
      valid_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        if (!valid_q && !flush) begin
          if (fetch_pc[1:0] != 2'b00) begin
            valid_nxt = 1'b1;
            pc_nxt    = fetch_pc;
            inst_nxt  = ERR_INST;
            err_nxt   = 1'b1;
          end else begin
            req_pc_nxt  = fetch_pc;
            araddr_nxt  = {fetch_pc[31:3], 3'b000};
            arvalid_nxt = 1'b1;
            state_nxt   = REQ;
          end
        end
      end
      REQ: begin
        // a request already on the bus cannot be withdrawn; remember to drop its beat
        if (flush) drop_nxt = 1'b1;
        if (mem_arready) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          rready_nxt = 1'b0;
          state_nxt  = IDLE;
          drop_nxt   = 1'b0;
          if (!drop_q && !flush) begin
            valid_nxt = 1'b1;
            pc_nxt    = req_pc_q;
            if (mem_rresp == 2'b00) begin
              err_nxt  = 1'b0;
              inst_nxt = req_pc_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
            end else begin
              err_nxt  = 1'b1;
              inst_nxt = ERR_INST;
            end
          end
        end else if (flush) begin
          drop_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_arvalid = arvalid_q;
  assign mem_araddr  = araddr_q;
  assign mem_rready  = rready_q;
  assign if_id_valid = valid_q;
  assign if_id_pc    = pc_q;
  assign if_id_inst  = inst_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_ysyx_22050854_ifu_fetch.sv
// Bench for ysyx_22050854_ifu_fetch: directed scenarios plus randomized fetches against a word-addressed memory model.
module tb_ysyx_22050854_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        stall, flush;
  logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;
  logic [31:0] mem_araddr;
  logic [63:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        if_id_valid, fetch_err;
  logic [31:0] if_id_pc, if_id_inst;

  int errors = 0;
  int checks = 0;
  int hs_count = 0;

  logic [63:0] mem [logic [28:0]];
  logic [31:0] exp_pc, exp_inst;
  logic        exp_err;

  ysyx_22050854_ifu_fetch dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .stall(stall), .flush(flush),
    .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arready(mem_arready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
    .mem_rready(mem_rready), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
    .if_id_inst(if_id_inst), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && mem_arvalid && mem_arready) hs_count++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: 32-bit little-endian word at pc from a 64-bit beat; bus error yields all-zero inst.
  function automatic logic [31:0] ref_inst(input logic [31:0] pc, input logic [63:0] beat, input logic [1:0] resp);
    logic [63:0] sh;
    if (resp != 2'b00) return 32'h0;
    sh = beat >> (32 * ((pc / 4) % 2));
    return sh[31:0];
  endfunction

  task automatic check_held(input string tag);
    chk({tag, "_valid"}, {63'h0, if_id_valid}, 64'h1);
    chk({tag, "_pc"}, {32'h0, if_id_pc}, {32'h0, exp_pc});
    chk({tag, "_inst"}, {32'h0, if_id_inst}, {32'h0, exp_inst});
    chk({tag, "_err"}, {63'h0, fetch_err}, {63'h0, exp_err});
  endtask

  // Issues from IDLE with IF/ID empty; memory answers after ard arready-low cycles and rd rvalid-low cycles.
  task automatic do_fetch(input logic [31:0] pc, input int ard, input int rd, input logic [1:0] resp);
    logic [63:0] beat;
    int hs0;
    hs0 = hs_count;
    beat = mem.exists(pc[31:3]) ? mem[pc[31:3]] : 64'h0;
    fetch_pc = pc;
    tick();
    chk("issue_arvalid", {63'h0, mem_arvalid}, 64'h1);
    chk("issue_araddr", {32'h0, mem_araddr}, {32'h0, pc & 32'hFFFF_FFF8});
    for (int i = 0; i < ard; i++) begin
      tick();
      chk("bp_arvalid", {63'h0, mem_arvalid}, 64'h1);
      chk("bp_araddr", {32'h0, mem_araddr}, {32'h0, pc & 32'hFFFF_FFF8});
    end
    mem_arready = 1'b1;
    tick();
    mem_arready = 1'b0;
    chk("hs_arvalid", {63'h0, mem_arvalid}, 64'h0);
    chk("hs_rready", {63'h0, mem_rready}, 64'h1);
    for (int i = 0; i < rd; i++) begin
      tick();
      chk("wait_valid", {63'h0, if_id_valid}, 64'h0);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = beat;
    mem_rresp  = resp;
    tick();
    mem_rvalid = 1'b0;
    exp_pc   = pc;
    exp_inst = ref_inst(pc, beat, resp);
    exp_err  = (resp != 2'b00);
    check_held("load");
    chk("load_rready", {63'h0, mem_rready}, 64'h0);
    chk("one_handshake", 64'(hs_count - hs0), 64'h1);
  endtask

  task automatic consume();
    stall = 1'b0;
    tick();
    stall = 1'b1;
    chk("consume_valid", {63'h0, if_id_valid}, 64'h0);
  endtask

  task automatic misaligned(input logic [31:0] pc);
    fetch_pc = pc;
    tick();
    chk("mis_arvalid", {63'h0, mem_arvalid}, 64'h0);
    exp_pc = pc; exp_inst = 32'h0; exp_err = 1'b1;
    check_held("mis");
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_arvalid"}, {63'h0, mem_arvalid}, 64'h0);
    chk({tag, "_araddr"}, {32'h0, mem_araddr}, 64'h0);
    chk({tag, "_rready"}, {63'h0, mem_rready}, 64'h0);
    chk({tag, "_valid"}, {63'h0, if_id_valid}, 64'h0);
    chk({tag, "_pc"}, {32'h0, if_id_pc}, 64'h0);
    chk({tag, "_inst"}, {32'h0, if_id_inst}, 64'h13);
    chk({tag, "_err"}, {63'h0, fetch_err}, 64'h0);
  endtask

  initial begin
    logic [31:0] rpc;
    rst = 1'b1; stall = 1'b1; flush = 1'b0; fetch_pc = 32'h8000_0000;
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'h0; mem_rresp = 2'b00;
    mem[29'h1000_0000] = 64'h00500093_00100093;
    tick(); tick();
    check_reset("reset");
    rst = 1'b0;

    // lower then upper word, minimum latency
    do_fetch(32'h8000_0000, 0, 0, 2'b00);
    // stall hold
    for (int i = 0; i < 5; i++) begin
      tick();
      check_held("stall_hold");
      chk("stall_arvalid", {63'h0, mem_arvalid}, 64'h0);
    end
    consume();
    do_fetch(32'h8000_0004, 0, 0, 2'b00);
    consume();

    // arready backpressure
    mem[29'h1000_0002] = 64'hDEADBEEF_CAFEF00D;
    do_fetch(32'h8000_0010, 3, 1, 2'b00);
    // flush of a held instruction restores the NOP
    flush = 1'b1; stall = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", {63'h0, if_id_valid}, 64'h0);
    chk("flush_inst", {32'h0, if_id_inst}, 64'h13);
    chk("flush_err", {63'h0, fetch_err}, 64'h0);

    // flush during WAIT: beat arrives 2 cycles later and is dropped
    fetch_pc = 32'h8000_0000;
    tick();
    mem_arready = 1'b1; tick(); mem_arready = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 64'h1111_2222_3333_4444; mem_rresp = 2'b00;
    tick();
    mem_rvalid = 1'b0;
    chk("drop_wait_valid", {63'h0, if_id_valid}, 64'h0);
    chk("drop_wait_rready", {63'h0, mem_rready}, 64'h0);
    do_fetch(32'h8000_0004, 0, 0, 2'b00);
    consume();

    // flush in REQ keeps the request up and drops the beat
    fetch_pc = 32'h8000_0010;
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_req_arvalid", {63'h0, mem_arvalid}, 64'h1);
    mem_arready = 1'b1; tick(); mem_arready = 1'b0;
    mem_rvalid = 1'b1; tick(); mem_rvalid = 1'b0;
    chk("drop_req_valid", {63'h0, if_id_valid}, 64'h0);

    // flush coinciding with rvalid
    tick();
    mem_arready = 1'b1; tick(); mem_arready = 1'b0;
    mem_rvalid = 1'b1; flush = 1'b1; tick(); mem_rvalid = 1'b0; flush = 1'b0;
    chk("drop_same_valid", {63'h0, if_id_valid}, 64'h0);

    // error paths
    do_fetch(32'h8000_0000, 1, 2, 2'b10);
    consume();
    misaligned(32'h8000_0002);
    tick();
    chk("mis_hold_arvalid", {63'h0, mem_arvalid}, 64'h0);
    consume();

    // reset while in WAIT
    fetch_pc = 32'h8000_0008;
    tick();
    mem_arready = 1'b1; tick(); mem_arready = 1'b0;
    rst = 1'b1; tick();
    check_reset("rst_wait");
    rst = 1'b0;

    // randomized fetches
    for (int n = 0; n < 40; n++) begin
      rpc = 32'h8000_0000 + ($urandom_range(0, 63) * 4);
      if ($urandom_range(0, 7) == 0) begin
        misaligned(rpc | 32'($urandom_range(1, 3)));
      end else begin
        mem[rpc[31:3]] = {$urandom, $urandom};
        do_fetch(rpc, $urandom_range(0, 3), $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      end
      for (int s = $urandom_range(0, 2); s > 0; s--) begin
        tick();
        check_held("rand_hold");
      end
      consume();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
